// File: rtl/pc_stack_ctrl_pkg.sv
// Shared definitions for the PC / return-stack controller: default sizes,
// the action encoding produced by the request priority encoder, and the
// encoder itself.
package pc_stack_ctrl_pkg;

    localparam int              PC_W_DEF         = 13;
    localparam int              STACK_DEPTH_DEF  = 8;
    localparam logic [12:0]     RESET_VECTOR_DEF = 13'h0000;

    // One action is resolved per cycle; the enum lists them lowest to highest
    // priority.
    typedef enum logic [2:0] {
        act_none  = 3'd0,
        act_incr  = 3'd1,
        act_pclwr = 3'd2,
        act_jump  = 3'd3,
        act_call  = 3'd4,
        act_ret   = 3'd5
    } act_e;

    // Collapse simultaneous requests to the single highest-priority action.
    function automatic act_e encode_action(input logic ret,
                                           input logic call,
                                           input logic jump,
                                           input logic pclwr,
                                           input logic incr);
        if (ret)        return act_ret;
        else if (call)  return act_call;
        else if (jump)  return act_jump;
        else if (pclwr) return act_pclwr;
        else if (incr)  return act_incr;
        else            return act_none;
    endfunction

endpackage

// File: rtl/pc_stack_ctrl_if.sv
// Decoder-facing bundle: request pulses and operands in, fetch address and
// stack status out. The decoder side is the master.
interface pc_stack_ctrl_if
    import pc_stack_ctrl_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int DEPTH_W = 4
);
    logic               pc_incr_en;
    logic               pc_j_en;
    logic               call_en;
    logic               ret_en;
    logic [10:0]        j_addr;
    logic [4:0]         pclath;
    logic               pcl_wr_en;
    logic [7:0]         pcl_wr_data;
    logic               clr_stack_flags;
    logic [PC_W-1:0]    pc;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_overflow;
    logic               stack_underflow;

    modport master (
        output pc_incr_en, pc_j_en, call_en, ret_en, j_addr, pclath,
               pcl_wr_en, pcl_wr_data, clr_stack_flags,
        input  pc, stack_depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  pc_incr_en, pc_j_en, call_en, ret_en, j_addr, pclath,
               pcl_wr_en, pcl_wr_data, clr_stack_flags,
        output pc, stack_depth, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/pc_stack_ctrl_return_stack.sv
// Circular hardware return stack. sp is the next free slot; depth saturates
// at DEPTH on push (oldest entry is silently overwritten) and at 0 on pop
// (the stale slot below sp is still presented). Storage is never reset.
module return_stack
    import pc_stack_ctrl_pkg::*;
#(
    parameter int DATA_W  = PC_W_DEF,
    parameter int DEPTH   = STACK_DEPTH_DEF,
    parameter int DEPTH_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               clr_flags,
    output logic [DATA_W-1:0]  top_data,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);
    localparam int SP_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [SP_W-1:0]    sp_q;
    logic [SP_W-1:0]    sp_m1;
    logic [DEPTH_W-1:0] depth_q;
    logic               do_push;
    logic               ovf_evt;
    logic               unf_evt;

    // Pop wins if both are ever presented together.
    assign do_push  = push & ~pop;
    assign sp_m1    = sp_q - 1'b1;
    assign top_data = mem[sp_m1];
    assign ovf_evt  = do_push && (depth_q == DEPTH_W'(DEPTH));
    assign unf_evt  = pop && (depth_q == '0);
    assign depth    = depth_q;

    // Storage write; reset blocks the write but never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[sp_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            depth_q <= '0;
        end else if (pop) begin
            sp_q <= sp_m1;
            if (!unf_evt) depth_q <= depth_q - 1'b1;
        end else if (do_push) begin
            sp_q <= sp_q + 1'b1;
            if (!ovf_evt) depth_q <= depth_q + 1'b1;
        end
    end

    // Sticky error flags; a fresh event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)        overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (unf_evt)        underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_stack_ctrl.sv
// Program counter and return-stack controller. Resolves the decoder's request
// pulses into one PC update per cycle and drives the return stack.
module pc_stack_ctrl
    import pc_stack_ctrl_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEF,
    parameter int              STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF)
) (
    input  logic           clk,
    input  logic           rst,
    pc_stack_ctrl_if.slave bus
);
    act_e            act;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pclwr_target;
    logic [PC_W-1:0] top_data;
    logic            push;
    logic            pop;

    // Pick the single action for this cycle.
    always_comb begin
        act = encode_action(bus.ret_en, bus.call_en, bus.pc_j_en,
                            bus.pcl_wr_en, bus.pc_incr_en);
    end

    assign pc_plus1     = pc_q + 1'b1;
    assign jump_target  = PC_W'({bus.pclath[4:3], bus.j_addr});
    assign pclwr_target = PC_W'({bus.pclath, bus.pcl_wr_data});
    assign push         = (act == act_call);
    assign pop          = (act == act_ret);

    // Next-PC mux; CALL and GOTO share the same page-extended target.
    always_comb begin
        pc_next = pc_q;
        case (act)
            act_ret:   pc_next = top_data;
            act_call:  pc_next = jump_target;
            act_jump:  pc_next = jump_target;
            act_pclwr: pc_next = pclwr_target;
            act_incr:  pc_next = pc_plus1;
            default:   pc_next = pc_q;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_next;
    end

    assign bus.pc = pc_q;

    return_stack #(
        .DATA_W (PC_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .clr_flags (bus.clr_stack_flags),
        .top_data  (top_data),
        .depth     (bus.stack_depth),
        .overflow  (bus.stack_overflow),
        .underflow (bus.stack_underflow)
    );

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Bench for pc_stack_ctrl: directed scenarios plus a randomized run against
// an arithmetic model of the PC and an 8-slot circular stack.
module tb_pc_stack_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_stack_ctrl_if #(.PC_W(13), .DEPTH_W(4)) bif ();

    pc_stack_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state.
    logic [12:0] m_pc;
    logic [12:0] m_mem [8];
    bit          m_written [8];
    int          m_sp;
    int          m_depth;
    bit          m_ovf;
    bit          m_unf;

    // Current request.
    bit          r_rst, r_inc, r_j, r_call, r_ret, r_pw, r_clr;
    logic [10:0] r_ja;
    logic [4:0]  r_pl;
    logic [7:0]  r_pd;

    task automatic model_step();
        bit ovf_evt = 0;
        bit unf_evt = 0;
        if (r_rst) begin
            m_pc = 13'h0000; m_sp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        if (r_ret) begin
            m_sp = (m_sp + 7) % 8;
            m_pc = m_mem[m_sp];
            if (m_depth == 0) unf_evt = 1; else m_depth = m_depth - 1;
        end else if (r_call) begin
            m_mem[m_sp] = 13'((int'(m_pc) + 1) % 8192);
            m_written[m_sp] = 1;
            m_sp = (m_sp + 1) % 8;
            if (m_depth == 8) ovf_evt = 1; else m_depth = m_depth + 1;
            m_pc = 13'(int'(r_pl[4:3]) * 2048 + int'(r_ja));
        end else if (r_j) begin
            m_pc = 13'(int'(r_pl[4:3]) * 2048 + int'(r_ja));
        end else if (r_pw) begin
            m_pc = 13'(int'(r_pl) * 256 + int'(r_pd));
        end else if (r_inc) begin
            m_pc = 13'((int'(m_pc) + 1) % 8192);
        end
        if (r_clr) begin m_ovf = 0; m_unf = 0; end
        if (ovf_evt) m_ovf = 1;
        if (unf_evt) m_unf = 1;
    endtask

    task automatic idle_inputs();
        bif.pc_incr_en = 0; bif.pc_j_en = 0; bif.call_en = 0; bif.ret_en = 0;
        bif.pcl_wr_en = 0; bif.clr_stack_flags = 0;
        bif.j_addr = '0; bif.pclath = '0; bif.pcl_wr_data = '0;
        rst = 0;
    endtask

    // One clock with the given requests; inputs return to idle afterwards.
    task automatic cycle(input bit rs, input bit inc, input bit j, input bit cl,
                         input bit rt, input bit pw, input bit clr,
                         input logic [10:0] ja, input logic [4:0] pl,
                         input logic [7:0] pd);
        r_rst = rs; r_inc = inc; r_j = j; r_call = cl; r_ret = rt; r_pw = pw;
        r_clr = clr; r_ja = ja; r_pl = pl; r_pd = pd;
        rst = rs; bif.pc_incr_en = inc; bif.pc_j_en = j; bif.call_en = cl;
        bif.ret_en = rt; bif.pcl_wr_en = pw; bif.clr_stack_flags = clr;
        bif.j_addr = ja; bif.pclath = pl; bif.pcl_wr_data = pd;
        @(posedge clk);
        #1;
        model_step();
        idle_inputs();
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        cycle(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        n_cmp++; if (bif.pc !== 13'h0000) begin n_err++; $display("FAIL reset_pc got %h want 0000", bif.pc); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL reset_depth got %0d want 0", bif.stack_depth); end
        n_cmp++; if (bif.stack_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bif.stack_overflow); end
        n_cmp++; if (bif.stack_underflow !== 1'b0) begin n_err++; $display("FAIL reset_unf got %b want 0", bif.stack_underflow); end
    endtask

    task automatic test_increment();
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
        n_cmp++; if (bif.pc !== 13'h0003) begin n_err++; $display("FAIL incr3 got %h want 0003", bif.pc); end
        cycle(0, 0, 0, 0, 0, 1, 0, '0, 5'h1F, 8'hFF);
        n_cmp++; if (bif.pc !== 13'h1FFF) begin n_err++; $display("FAIL pclwr_1fff got %h want 1fff", bif.pc); end
        cycle(0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
        n_cmp++; if (bif.pc !== 13'h0000) begin n_err++; $display("FAIL incr_wrap got %h want 0000", bif.pc); end
    endtask

    task automatic test_call_ret();
        cycle(0, 0, 0, 0, 0, 1, 0, '0, 5'h00, 8'h40);
        cycle(0, 0, 0, 1, 0, 0, 0, 11'h123, 5'b11000, '0);
        n_cmp++; if (bif.pc !== 13'h1923) begin n_err++; $display("FAIL call_pc got %h want 1923", bif.pc); end
        n_cmp++; if (bif.stack_depth !== 4'd1) begin n_err++; $display("FAIL call_depth got %0d want 1", bif.stack_depth); end
        cycle(0, 0, 0, 0, 1, 0, 0, '0, '0, '0);
        n_cmp++; if (bif.pc !== 13'h0041) begin n_err++; $display("FAIL ret_pc got %h want 0041", bif.pc); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL ret_depth got %0d want 0", bif.stack_depth); end
    endtask

    task automatic test_overflow();
        logic [12:0] ra [9];
        cycle(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        for (int i = 0; i < 9; i++) begin
            ra[i] = 13'(i * 256 + 17);
            cycle(0, 0, 0, 0, 0, 1, 0, '0, 5'(i), 8'h10);
            cycle(0, 0, 0, 1, 0, 0, 0, 11'h0AA, 5'h00, '0);
        end
        n_cmp++; if (bif.stack_depth !== 4'd8) begin n_err++; $display("FAIL ovf_depth got %0d want 8", bif.stack_depth); end
        n_cmp++; if (bif.stack_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", bif.stack_overflow); end
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0, 1, 0, 0, '0, '0, '0);
            n_cmp++; if (bif.pc !== ra[8 - k]) begin n_err++; $display("FAIL ovf_pop%0d got %h want %h", k, bif.pc, ra[8 - k]); end
        end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL ovf_drained got %0d want 0", bif.stack_depth); end
        cycle(0, 0, 0, 0, 1, 0, 0, '0, '0, '0);
        n_cmp++; if (bif.pc !== ra[8]) begin n_err++; $display("FAIL wrap_pop got %h want %h", bif.pc, ra[8]); end
        n_cmp++; if (bif.stack_underflow !== 1'b1) begin n_err++; $display("FAIL wrap_unf got %b want 1", bif.stack_underflow); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL wrap_depth got %0d want 0", bif.stack_depth); end
    endtask

    task automatic test_flags();
        cycle(0, 0, 0, 0, 0, 0, 1, '0, '0, '0);
        n_cmp++; if (bif.stack_underflow !== 1'b0) begin n_err++; $display("FAIL clr_unf got %b want 0", bif.stack_underflow); end
        n_cmp++; if (bif.stack_overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", bif.stack_overflow); end
        cycle(0, 0, 0, 0, 1, 0, 1, '0, '0, '0);
        n_cmp++; if (bif.stack_underflow !== 1'b1) begin n_err++; $display("FAIL clr_vs_unf got %b want 1", bif.stack_underflow); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL clr_vs_unf_depth got %0d want 0", bif.stack_depth); end
        n_cmp++; if (bif.pc !== m_pc) begin n_err++; $display("FAIL stale_pop got %h want %h", bif.pc, m_pc); end
    endtask

    task automatic test_priority();
        cycle(0, 1, 0, 0, 0, 1, 0, '0, 5'h03, 8'h7E);
        n_cmp++; if (bif.pc !== 13'h037E) begin n_err++; $display("FAIL pclwr_vs_incr got %h want 037e", bif.pc); end
        cycle(0, 1, 1, 0, 0, 1, 0, 11'h255, 5'h08, 8'h11);
        n_cmp++; if (bif.pc !== 13'h0A55) begin n_err++; $display("FAIL jump_vs_pclwr got %h want 0a55", bif.pc); end
        cycle(1, 0, 0, 1, 0, 0, 0, 11'h321, 5'h18, '0);
        n_cmp++; if (bif.pc !== 13'h0000) begin n_err++; $display("FAIL rst_vs_call_pc got %h want 0000", bif.pc); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL rst_vs_call_depth got %0d want 0", bif.stack_depth); end
        cycle(0, 0, 0, 1, 0, 0, 0, 11'h050, 5'h08, '0);
        cycle(0, 0, 0, 1, 1, 0, 0, 11'h777, 5'h18, '0);
        n_cmp++; if (bif.pc !== 13'h0001) begin n_err++; $display("FAIL ret_vs_call_pc got %h want 0001", bif.pc); end
        n_cmp++; if (bif.stack_depth !== 4'd0) begin n_err++; $display("FAIL ret_vs_call_depth got %0d want 0", bif.stack_depth); end
    endtask

    task automatic test_random();
        bit rs, inc, j, cl, rt, pw, clr;
        for (int n = 0; n < 400; n++) begin
            rs  = ($urandom_range(0, 49) == 0);
            inc = ($urandom_range(0, 1) == 1);
            j   = ($urandom_range(0, 5) == 0);
            cl  = ($urandom_range(0, 3) == 0);
            rt  = ($urandom_range(0, 3) == 0);
            pw  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 7) == 0);
            if (!m_written[(m_sp + 7) % 8]) rt = 0;
            cycle(rs, inc, j, cl, rt, pw, clr, 11'($urandom), 5'($urandom), 8'($urandom));
            n_cmp++; if (bif.pc !== m_pc) begin n_err++; $display("FAIL rand_pc cyc %0d got %h want %h", n, bif.pc, m_pc); end
            n_cmp++; if (bif.stack_depth !== 4'(m_depth)) begin n_err++; $display("FAIL rand_depth cyc %0d got %0d want %0d", n, bif.stack_depth, m_depth); end
            n_cmp++; if (bif.stack_overflow !== m_ovf) begin n_err++; $display("FAIL rand_ovf cyc %0d got %b want %b", n, bif.stack_overflow, m_ovf); end
            n_cmp++; if (bif.stack_underflow !== m_unf) begin n_err++; $display("FAIL rand_unf cyc %0d got %b want %b", n, bif.stack_underflow, m_unf); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_written[i] = 0; end
        m_pc = '0; m_sp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_increment();
        test_call_ret();
        test_overflow();
        test_flags();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
